pipelined_csa_adder: RTL and testbench



---
 rtl/pipelined_csa_adder.sv | 131 +++++++++++++
 tb/tb_pipelined_csa_adder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csa_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipelined_csa_adder: pipelined carry-select add/sub, one BLOCK slice per   |
// | stage, valid/ready on both sides. Optional clamp: CSA_SATURATE_EN.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipelined_csa_adder #(
  parameter int WIDTH = 64,
  parameter int BLOCK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSTAGE = WIDTH / BLOCK;

  // Per-stage word: resolved sum slices at the bottom, still-unresolved
  // operand A slices above them. B travels alongside in its own word.
  logic [NSTAGE-1:0]            vld_q, vld_d;
  logic [NSTAGE-1:0][WIDTH-1:0] word_q, word_d;
  logic [NSTAGE-1:0][WIDTH-1:0] bop_q, bop_d;
  logic [NSTAGE-1:0]            cy_q, cy_d;
  logic                         ovf_q, ovf_d;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] src_w;
  logic [WIDTH-1:0] src_b;
  logic             src_c;
  logic             src_v;
  logic [BLOCK:0]   sel0;
  logic [BLOCK:0]   sel1;
  logic [BLOCK:0]   sel;

  always_comb begin
    advance = !vld_q[NSTAGE-1] || out_ready;
    b_eff   = sub ? ~b : b;
    cin_eff = sub ? 1'b1 : c_in;

    vld_d  = vld_q;
    word_d = word_q;
    bop_d  = bop_q;
    cy_d   = cy_q;
    ovf_d  = ovf_q;
    src_w  = '0;
    src_b  = '0;
    src_c  = 1'b0;
    src_v  = 1'b0;
    sel0   = '0;
    sel1   = '0;
    sel    = '0;

    for (int k = 0; k < NSTAGE; k++) begin
      if (k == 0) begin
        src_w = a;
        src_b = b_eff;
        src_c = cin_eff;
        src_v = in_valid;
      end else begin
        src_w = word_q[k-1];
        src_b = bop_q[k-1];
        src_c = cy_q[k-1];
        src_v = vld_q[k-1];
      end

      sel0 = {1'b0, src_w[k*BLOCK +: BLOCK]} + {1'b0, src_b[k*BLOCK +: BLOCK]};
      sel1 = sel0 + (BLOCK+1)'(1);
      sel  = src_c ? sel1 : sel0;

      // Bubbles advance the valid bits but leave the data registers alone,
      // so the output word keeps its last value while out_valid is low.
      if (advance) begin
        vld_d[k] = src_v;
        if (src_v) begin
          word_d[k]                    = src_w;
          word_d[k][k*BLOCK +: BLOCK]  = sel[BLOCK-1:0];
          bop_d[k]                     = src_b;
          cy_d[k]                      = sel[BLOCK];
          if (k == NSTAGE-1) begin
            // Top slice of src_w is still operand A, so its MSB is a[MSB].
            ovf_d = (src_w[WIDTH-1] == src_b[WIDTH-1]) &&
                    (word_d[k][WIDTH-1] != src_w[WIDTH-1]);
`ifdef CSA_SATURATE_EN
            if (ovf_d) begin
              word_d[k] = src_w[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
            end
`else
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      word_q <= '0;
      bop_q  <= '0;
      cy_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      word_q <= word_d;
      bop_q  <= bop_d;
      cy_q   <= cy_d;
      ovf_q  <= ovf_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[NSTAGE-1];
  assign sum       = word_q[NSTAGE-1];
  assign c_out     = cy_q[NSTAGE-1];
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_csa_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipelined_csa_adder: directed table, stall/stream and reset sequences   |
// | on 64/16, plus back-to-back streams on 32/8 and 16/16 instances.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipelined_csa_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 64-bit / 16-bit slice instance
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [63:0] a = '0, b = '0, sum;
  logic        c_in = 1'b0, sub = 1'b0, c_out, ovf;

  pipelined_csa_adder #(.WIDTH(64), .BLOCK(16)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf));

  // 32-bit / 8-bit slice instance
  logic        iv32 = 1'b0, ir32, ov32v, or32 = 1'b1;
  logic [31:0] a32 = '0, b32 = '0, s32;
  logic        ci32 = 1'b0, sb32 = 1'b0, co32, of32;

  pipelined_csa_adder #(.WIDTH(32), .BLOCK(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .c_in(ci32), .sub(sb32), .out_valid(ov32v),
    .out_ready(or32), .sum(s32), .c_out(co32), .ovf(of32));

  // 16-bit single-stage instance
  logic        iv16 = 1'b0, ir16, ov16v, or16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        ci16 = 1'b0, sb16 = 1'b0, co16, of16;

  pipelined_csa_adder #(.WIDTH(16), .BLOCK(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .c_in(ci16), .sub(sb16), .out_valid(ov16v),
    .out_ready(or16), .sum(s16), .c_out(co16), .ovf(of16));

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

`ifdef CSA_SATURATE_EN
  localparam logic [63:0] S_POS_OVF = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] S_NEG_ADD = 64'h8000_0000_0000_0000;
  localparam logic [63:0] S_NEG_SUB = 64'h8000_0000_0000_0000;
  localparam logic [63:0] S_POS_SUB = 64'h7FFF_FFFF_FFFF_FFFF;
`else
  localparam logic [63:0] S_POS_OVF = 64'h8000_0000_0000_0000;
  localparam logic [63:0] S_NEG_ADD = 64'h0000_0000_0000_0000;
  localparam logic [63:0] S_NEG_SUB = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] S_POS_SUB = 64'h8000_0000_0000_0000;
`endif

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Plain full-width reference: {c_out, ovf, sum} for a w-bit adder.
  function automatic logic [65:0] model(input int w, input logic [63:0] av,
                                        input logic [63:0] bv, input logic ci,
                                        input logic sb);
    logic [63:0] mask, am, be, s;
    logic [64:0] full;
    logic        co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = av & mask;
    be   = (sb ? ~bv : bv) & mask;
    full = {1'b0, am} + {1'b0, be} + (sb ? 65'd1 : {64'd0, ci});
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
`ifdef CSA_SATURATE_EN
    if (ov) s = am[w-1] ? (64'd1 << (w-1)) : (mask >> 1);
`endif
    return {co, ov, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated op on the 64-bit instance: latency, result, then hold.
  task automatic run_one(input vec_t v, input int idx);
    int lat;
    a = v.a; b = v.b; c_in = v.cin; sub = v.sub;
    in_valid = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 12);
    check($sformatf("vec%0d latency", idx), 72'(lat), 72'd4);
    check($sformatf("vec%0d sum", idx), 72'(sum), 72'(v.sum));
    check($sformatf("vec%0d c_out/ovf", idx), 72'({c_out, ovf}), 72'({v.cout, v.ovf}));
    tick();
    check($sformatf("vec%0d idle hold", idx), {7'd0, out_valid, sum}, {8'd0, v.sum});
  endtask

  vec_t tv [12];
  logic [65:0] q_exp [$];
  logic [65:0] e;
  logic [65:0] exp32 [1000];
  logic [65:0] exp16 [1000];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
    tv[1]  = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tv[2]  = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
    tv[3]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, S_POS_OVF, 1'b0, 1'b1};
    tv[4]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, S_NEG_ADD, 1'b1, 1'b1};
    tv[5]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, S_NEG_SUB, 1'b1, 1'b1};
    tv[6]  = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    tv[7]  = '{64'h0000_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0};
    tv[8]  = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0};
    tv[9]  = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
               64'h2222_2222_2222_2211, 1'b0, 1'b0};
    tv[10] = '{64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};
    tv[11] = '{64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, S_POS_SUB, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset outputs", {5'd0, in_ready, out_valid, c_out, ovf, sum},
          {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0});

    for (int i = 0; i < 12; i++) run_one(tv[i], i);

    // Back-to-back stream with random backpressure
    begin
      int sent, got;
      logic held, held_co, held_ov;
      logic [63:0] held_sum;
      sent = 0; got = 0; held = 1'b0; held_co = 1'b0; held_ov = 1'b0; held_sum = '0;
      for (int cyc = 0; cyc < 300 && got < 16; cyc++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (sent < 16) begin
          in_valid = 1'b1;
          a = {$urandom, $urandom};
          b = {$urandom, $urandom};
          c_in = 1'($urandom_range(0, 1));
          sub = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
        #1;
        check("stream in_ready", 72'(in_ready), 72'(!(out_valid && !out_ready)));
        if (held)
          check("stream stall hold", {5'd0, out_valid, c_out, ovf, sum},
                {5'd0, 1'b1, held_co, held_ov, held_sum});
        held = out_valid && !out_ready;
        held_co = c_out; held_ov = ovf; held_sum = sum;
        if (in_valid && in_ready) begin
          q_exp.push_back(model(64, a, b, c_in, sub));
          sent++;
        end
        if (out_valid && out_ready) begin
          if (q_exp.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL stream extra result: got %h expected none", sum);
          end else begin
            e = q_exp.pop_front();
            check("stream result", {6'd0, c_out, ovf, sum}, {6'd0, e});
          end
          got++;
        end
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("stream result count", 72'(got), 72'd16);
      check("stream leftover", 72'(q_exp.size()), 72'd0);
      tick();
    end

    // Reset with three ops in flight, output stalled
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 64'd100; b = 64'(i); c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("pre-reset out_valid", 72'(out_valid), 72'd1);
    #1 rst = 1'b1;
    #1;
    check("async reset clears", {7'd0, out_valid, sum}, 72'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    begin
      vec_t nv;
      nv = '{64'd1, 64'd2, 1'b0, 1'b0, 64'd3, 1'b0, 1'b0};
      run_one(nv, 100);
    end

    // 32/8 and 16/16 instances: 1000 back-to-back random ops each
    for (int j = 0; j < 1003; j++) begin
      if (j < 1000) begin
        iv32 = 1'b1; iv16 = 1'b1;
        a32 = (($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom);
        b32 = $urandom;
        ci32 = 1'($urandom_range(0, 1)); sb32 = 1'($urandom_range(0, 1));
        a16 = (($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom));
        b16 = 16'($urandom);
        ci16 = 1'($urandom_range(0, 1)); sb16 = 1'($urandom_range(0, 1));
        exp32[j] = model(32, {32'd0, a32}, {32'd0, b32}, ci32, sb32);
        exp16[j] = model(16, {48'd0, a16}, {48'd0, b16}, ci16, sb16);
      end else begin
        iv32 = 1'b0; iv16 = 1'b0;
      end
      tick();
      if (j < 3)
        check("w32 pipeline fill", 72'(ov32v), 72'd0);
      else
        check($sformatf("w32 op%0d", j - 3), {5'd0, ov32v, co32, of32, 32'd0, s32},
              {5'd0, 1'b1, exp32[j-3]});
      if (j < 1000)
        check($sformatf("w16 op%0d", j), {5'd0, ov16v, co16, of16, 48'd0, s16},
              {5'd0, 1'b1, exp16[j]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
